cmp_minmax_tracker: RTL and testbench
=====================================

Name: cmp_minmax_tracker

Overview:
- Sequential stage downstream of the 8-bit magnitude comparator.
- Accepts a stream of unsigned samples with a valid/ready handshake and tracks running max, running min and sample count.
- Each accepted sample is compared against the previous sample and reported as a registered {V3,V2,V1} flag triple: greater, equal, less.
- Feeds the display/status logic with registered results only.

Parameters:
- WIDTH, 8, sample width in bits.
- CNT_W, 8, width of the sample counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of all tracked state; has priority over accept.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  unsigned sample.
- out_valid  output  1  one-cycle pulse: results updated for the sample accepted last cycle.
- max_val  output  WIDTH  running maximum.
- min_val  output  WIDTH  running minimum.
- sample_cnt  output  CNT_W  number of accepted samples.
- V3  output  1  last sample > previous sample.
- V2  output  1  last sample == previous sample.
- V1  output  1  last sample < previous sample.
- cnt_sat  output  1  counter saturated; block stalled.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=EMPTY.
  - max_val=0, min_val={WIDTH{1}}, sample_cnt=0.
  - V3=V2=V1=0, out_valid=0, cnt_sat=0, in_ready=0.
  - in_ready rises on the first clock edge after rst_n deasserts.
- Accept: a sample is accepted when in_valid && in_ready at a rising edge. All outputs update at that same edge, so latency is 1 cycle, and out_valid=1 for exactly that following cycle.
- FSM states:
  - EMPTY: no sample held.
    - On accept: max_val=min_val=in_data, sample_cnt=1, prev=in_data.
    - V2=1, V3=V1=0 (first sample compares equal to itself).
    - Go to TRACK.
  - TRACK:
    - On accept: if in_data>max_val then max_val=in_data; if in_data<min_val then min_val=in_data.
    - Flags come from comparing in_data against prev. Exactly one flag is set.
    - Update prev and increment sample_cnt.
    - If sample_cnt becomes 2^CNT_W-1, go to SAT.
  - SAT: in_ready=0, cnt_sat=1. Outputs are held until clear.
- in_ready = (state!=SAT) && !clear, combinational from registered state.
- clear (any state): next state EMPTY, all tracked registers back to reset values, out_valid=0. A sample presented in the same cycle is not accepted.
- Flags are only written on accept. Between accepts they hold their last value, and they are one-hot after the first accept.
- Equality against max/min leaves that register unchanged.
- Boundaries:
  - in_data=0 or all-ones is handled with no wrap.
  - Counter never wraps; it saturates at 2^CNT_W-1.
  - rst_n asserted mid-stream clears everything immediately, regardless of clk.
- No combinational path from in_data to any output.

Decomposition:
- Shared package holds:
  - state encoding constants EMPTY=2'd0, TRACK=2'd1, SAT=2'd2;
  - flag index constants GT=2, EQ=1, LT=0.
- Sub-module: the existing combinational Comparator8Bit is instantiated three times (sample vs prev, vs max, vs min).
- No other sub-modules.

Test Plan:
- Reset, then sample 0 -> next cycle: max=0, min=0, cnt=1, V2=1, out_valid pulse.
- Samples 8 then 7 -> after 7: V1=1, max=8, min=7, cnt=2.
- Samples 100, 120, 64, 78 -> after 120: V3=1, max=120. After 64: V1=1, min=64. After 78: V3=1, final max=120, min=64, cnt=4.
- Sample 32 twice -> second yields V2=1 with max/min unchanged. clear with in_valid=1 -> no accept; state EMPTY, cnt=0, min=8'hFF.
- CNT_W=3, stream 7 samples -> cnt=7, cnt_sat=1, in_ready=0. An 8th in_valid is ignored. clear restores in_ready=1.
- rst_n pulsed low between clock edges mid-stream -> all outputs at reset values immediately; first sample after release re-enters from EMPTY.

Source files
------------

// File: rtl/cmp_minmax_tracker_pkg.sv
// rtl/cmp_minmax_tracker_pkg.sv - shared state encoding and flag indices for the min/max tracker
package cmp_minmax_tracker_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        SAT   = 2'd2
    } state_e;

    // Bit positions inside the {greater, equal, less} comparison result
    localparam int GT     = 2;
    localparam int EQ     = 1;
    localparam int LT     = 0;
    localparam int FLAG_W = 3;

    localparam logic [FLAG_W-1:0] FLAG_GT = 3'b100;
    localparam logic [FLAG_W-1:0] FLAG_EQ = 3'b010;
    localparam logic [FLAG_W-1:0] FLAG_LT = 3'b001;

endpackage

// File: rtl/cmp_minmax_tracker_cmp.sv
// rtl/cmp_minmax_tracker_cmp.sv - combinational unsigned magnitude comparator, one-hot {gt,eq,lt}
module cmp_minmax_tracker_cmp
    import cmp_minmax_tracker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic [FLAG_W-1:0] res_o
);

    // Exactly one bit is set for any pair of operands
    always_comb begin
        res_o     = '0;
        res_o[GT] = (a_i > b_i);
        res_o[EQ] = (a_i == b_i);
        res_o[LT] = (a_i < b_i);
    end

endmodule

// File: rtl/cmp_minmax_tracker.sv
// rtl/cmp_minmax_tracker.sv - running max/min/count tracker with registered compare flags
module cmp_minmax_tracker
    import cmp_minmax_tracker_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             V3,
    output logic             V2,
    output logic             V1,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e              state_q;
    logic                alive_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    max_q;
    logic [WIDTH-1:0]    min_q;
    logic [WIDTH-1:0]    prev_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [FLAG_W-1:0]   flags_q;
    logic [FLAG_W-1:0]   res_prev;
    logic [FLAG_W-1:0]   res_max;
    logic [FLAG_W-1:0]   res_min;
    logic                accept;

    cmp_minmax_tracker_cmp #(.WIDTH(WIDTH)) u_cmp_prev (
        .a_i   (in_data),
        .b_i   (prev_q),
        .res_o (res_prev)
    );

    cmp_minmax_tracker_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .a_i   (in_data),
        .b_i   (max_q),
        .res_o (res_max)
    );

    cmp_minmax_tracker_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .a_i   (in_data),
        .b_i   (min_q),
        .res_o (res_min)
    );

    // alive_q keeps in_ready low until the first edge after reset release;
    // in_ready itself never depends on in_data
    always_comb begin
        in_ready = alive_q && (state_q != SAT) && !clear;
        accept   = in_valid && in_ready;
        cnt_d    = cnt_q + 1'b1;
    end

    // Tracker FSM with all results registered; clear beats accept, SAT blocks accept so the counter cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            alive_q     <= 1'b0;
            out_valid_q <= 1'b0;
            max_q       <= '0;
            min_q       <= '1;
            prev_q      <= '0;
            cnt_q       <= '0;
            flags_q     <= '0;
        end else begin
            alive_q <= 1'b1;
            if (clear) begin
                state_q     <= EMPTY;
                out_valid_q <= 1'b0;
                max_q       <= '0;
                min_q       <= '1;
                prev_q      <= '0;
                cnt_q       <= '0;
                flags_q     <= '0;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    prev_q <= in_data;
                    cnt_q  <= cnt_d;
                    case (state_q)
                        EMPTY: begin
                            max_q   <= in_data;
                            min_q   <= in_data;
                            flags_q <= FLAG_EQ;
                            state_q <= (cnt_d == CNT_MAX) ? SAT : TRACK;
                        end
                        default: begin
                            if (res_max == FLAG_GT) begin
                                max_q <= in_data;
                            end
                            if (res_min == FLAG_LT) begin
                                min_q <= in_data;
                            end
                            flags_q <= res_prev;
                            if (cnt_d == CNT_MAX) begin
                                state_q <= SAT;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign max_val    = max_q;
    assign min_val    = min_q;
    assign sample_cnt = cnt_q;
    assign V3         = flags_q[GT];
    assign V2         = flags_q[EQ];
    assign V1         = flags_q[LT];
    assign cnt_sat    = (state_q == SAT);

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// tb/tb_cmp_minmax_tracker.sv - self-checking bench for cmp_minmax_tracker
module tb_cmp_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;

    logic       a_ready, a_ov, a_v3, a_v2, a_v1, a_sat;
    logic [7:0] a_max, a_min, a_cnt;
    logic       b_ready, b_ov, b_v3, b_v2, b_v1, b_sat;
    logic [7:0] b_max, b_min;
    logic [2:0] b_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: index 0 is the CNT_W=8 instance, index 1 the CNT_W=3 instance
    int   cap    [2];
    bit   m_have [2];
    int   m_prev [2];
    int   m_max  [2];
    int   m_min  [2];
    int   m_cnt  [2];
    int   m_flag [2];
    bit   m_ov   [2];
    bit   m_alive;
    bit   acc    [2];
    int   last_d;

    always #5 clk = ~clk;

    cmp_minmax_tracker #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(a_ready), .in_data(in_data), .out_valid(a_ov),
        .max_val(a_max), .min_val(a_min), .sample_cnt(a_cnt),
        .V3(a_v3), .V2(a_v2), .V1(a_v1), .cnt_sat(a_sat)
    );

    cmp_minmax_tracker #(.WIDTH(8), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(b_ready), .in_data(in_data), .out_valid(b_ov),
        .max_val(b_max), .min_val(b_min), .sample_cnt(b_cnt),
        .V3(b_v3), .V2(b_v2), .V1(b_v1), .cnt_sat(b_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_have[i] = 0; m_prev[i] = 0; m_max[i] = 0; m_min[i] = 255;
        m_cnt[i] = 0; m_flag[i] = 0; m_ov[i] = 0;
    endtask

    function automatic bit model_ready(input int i, input logic c);
        return m_alive && (m_cnt[i] != cap[i]) && !c;
    endfunction

    task automatic model_edge(input int i, input logic c, input bit a, input int d);
        if (c) begin
            model_reset(i);
        end else begin
            m_ov[i] = a;
            if (a) begin
                if (!m_have[i]) begin
                    m_max[i] = d; m_min[i] = d; m_flag[i] = 3'b010;
                end else begin
                    m_flag[i] = (d > m_prev[i]) ? 3'b100 : (d == m_prev[i]) ? 3'b010 : 3'b001;
                    if (d > m_max[i]) m_max[i] = d;
                    if (d < m_min[i]) m_min[i] = d;
                end
                m_have[i] = 1;
                m_prev[i] = d;
                m_cnt[i]  = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " a.out_valid"}, a_ov, m_ov[0]);
        chk({tag, " a.max"}, a_max, m_max[0]);
        chk({tag, " a.min"}, a_min, m_min[0]);
        chk({tag, " a.cnt"}, a_cnt, m_cnt[0]);
        chk({tag, " a.flags"}, {a_v3, a_v2, a_v1}, m_flag[0]);
        chk({tag, " a.cnt_sat"}, a_sat, m_cnt[0] == cap[0]);
        chk({tag, " b.out_valid"}, b_ov, m_ov[1]);
        chk({tag, " b.max"}, b_max, m_max[1]);
        chk({tag, " b.min"}, b_min, m_min[1]);
        chk({tag, " b.cnt"}, b_cnt, m_cnt[1]);
        chk({tag, " b.flags"}, {b_v3, b_v2, b_v1}, m_flag[1]);
        chk({tag, " b.cnt_sat"}, b_sat, m_cnt[1] == cap[1]);
    endtask

    // One clock of stimulus: drive at the falling edge, check ready, clock, check results
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic c);
        in_valid = v; in_data = d; clear = c;
        #1;
        for (int i = 0; i < 2; i++) acc[i] = v && model_ready(i, c);
        chk({tag, " a.in_ready"}, a_ready, model_ready(0, c));
        chk({tag, " b.in_ready"}, b_ready, model_ready(1, c));
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, c, acc[i], int'(d));
        m_alive = 1;
        @(negedge clk);
        check_outputs(tag);
        in_valid = 1'b0; clear = 1'b0;
    endtask

    initial begin
        int   rv;
        logic rc;
        logic [7:0] rd;

        cap[0] = 255; cap[1] = 7;
        model_reset(0); model_reset(1);
        m_alive = 0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        chk("reset a.in_ready", a_ready, 1'b0);
        rst_n = 1'b1;
        step("release", 1'b1, 8'd5, 1'b0);

        // First sample 0
        step("s0", 1'b1, 8'd0, 1'b0);
        chk("s0 max const", a_max, 8'd0);
        chk("s0 min const", a_min, 8'd0);
        step("s0 idle", 1'b0, 8'd0, 1'b0);
        step("clr1", 1'b0, 8'd0, 1'b1);

        // 8 then 7
        step("s8", 1'b1, 8'd8, 1'b0);
        step("s7", 1'b1, 8'd7, 1'b0);
        chk("s7 V1 const", a_v1, 1'b1);
        step("clr2", 1'b0, 8'd0, 1'b1);

        // 100, 120, 64, 78
        step("s100", 1'b1, 8'd100, 1'b0);
        step("s120", 1'b1, 8'd120, 1'b0);
        step("s64", 1'b1, 8'd64, 1'b0);
        step("s78", 1'b1, 8'd78, 1'b0);
        chk("s78 max const", a_max, 8'd120);
        chk("s78 min const", a_min, 8'd64);
        chk("s78 cnt const", a_cnt, 8'd4);

        // 32 twice, then clear with in_valid held high
        step("s32a", 1'b1, 8'd32, 1'b0);
        step("s32b", 1'b1, 8'd32, 1'b0);
        step("clr_v", 1'b1, 8'd55, 1'b1);
        chk("clr_v min const", a_min, 8'hFF);

        // Saturation of the CNT_W=3 instance, extra sample ignored, clear restores ready
        for (int k = 0; k < 7; k++) step("sat_fill", 1'b1, 8'(k * 37 + 3), 1'b0);
        chk("sat b.cnt_sat const", b_sat, 1'b1);
        step("sat_8th", 1'b1, 8'd200, 1'b0);
        step("sat_8th2", 1'b1, 8'd1, 1'b0);
        step("sat_clr", 1'b0, 8'd0, 1'b1);
        step("sat_after", 1'b1, 8'd9, 1'b0);

        // Extreme values
        step("ext_ff", 1'b1, 8'hFF, 1'b0);
        step("ext_00", 1'b1, 8'h00, 1'b0);
        step("ext_ff2", 1'b1, 8'hFF, 1'b0);

        // Asynchronous reset between edges
        in_valid = 1'b0; clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset(0); model_reset(1); m_alive = 0;
        check_outputs("async_rst");
        chk("async_rst a.in_ready", a_ready, 1'b0);
        chk("async_rst b.in_ready", b_ready, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        m_alive = 1;
        check_outputs("post_rst");
        step("post_rst s", 1'b1, 8'd77, 1'b0);
        step("post_rst t", 1'b1, 8'd78, 1'b0);

        // Randomized traffic against the model
        last_d = 0;
        for (int k = 0; k < 400; k++) begin
            rv = $urandom_range(0, 7);
            rd = (rv == 0) ? 8'h00 : (rv == 1) ? 8'hFF : (rv == 2) ? 8'(last_d) : 8'($urandom_range(0, 255));
            rc = ($urandom_range(0, 24) == 0);
            step("rand", ($urandom_range(0, 3) != 0), rd, rc);
            last_d = int'(rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
